alu_pipe: RTL
=============

// Module: alu_pipe
// PURPOSE
//  Parametrised, pipelined successor to the team's 8-bit combinational mini ALU.
//  - Same 3-bit opcode map, now WIDTH bits wide, with a 2-stage registered datapath.
//  - valid/ready handshakes on input and output, status flags, and a completed-operation counter.
//  - Sits between an operand source (register file / sequencer) and a result sink that may stall.
// PARAMETERS
//  WIDTH    8   operand/result width in bits (>=2)
//  COUNT_W  16  width of op_count; wraps modulo 2**COUNT_W
// PORTS
//  clk        in   1        rising-edge clock, single domain
//  rst        in   1        synchronous, active-high reset
//  in_valid   in   1        operands + sel presented this cycle
//  in_ready   out  1        block accepts operands this cycle
//  a          in   WIDTH    operand A
//  b          in   WIDTH    operand B
//  sel        in   3        opcode (map below)
//  out_valid  out  1        y/flags valid
//  out_ready  in   1        sink accepts result this cycle
//  y          out  WIDTH    result
//  flag_z     out  1        y == 0
//  flag_c     out  1        add: carry-out; sub: borrow (a<b unsigned); else 0
//  flag_v     out  1        add/sub: signed two's-complement overflow; else 0
//  op_count   out  COUNT_W  number of results handed off (out_valid&&out_ready)
// BEHAVIOUR
//  - Opcodes: 000 y=0 | 001 a&b | 010 a|b | 011 a+b | 100 a-b | 101 a^b | 110 ~a | 111 all-ones.
//  - Arithmetic: modulo 2**WIDTH. Add: carry = bit WIDTH of a+b; v = (a[msb]==b[msb])&&(y[msb]!=a[msb]).
//  - Sub: borrow = (a<b) unsigned; v = (a[msb]!=b[msb])&&(y[msb]!=a[msb]).
//  - Stage 1 (S1): registers a, b, sel, s1_valid on input handshake (in_valid&&in_ready).
//  - Stage 2 (S2): computes from S1 regs and registers y, flags, out_valid.
//  - adv2 = !out_valid || out_ready.
//  - S2 loads when adv2: out_valid<=s1_valid; y/flags update only if s1_valid.
//  - in_ready = !s1_valid || adv2 (combinational; no dependency on in_valid).
//  - S1 loads when in_ready: s1_valid<=in_valid; operands captured only if in_valid.
//  - Latency: accepted at edge N -> out_valid high after edge N+1 (2 edges). Throughput 1/cycle with out_ready=1.
//  - Stall: out_valid&&!out_ready holds y/flags/out_valid stable. S1 holds one extra entry;
//    in_ready drops once S1 is also full. No transaction dropped or duplicated.
//  - Simultaneous: out handshake and new S1 data in the same cycle -> S2 replaced seamlessly, no bubble.
//  - Invalid input cycles insert bubbles: out_valid=0 on the corresponding cycle.
//  - op_count increments on each output handshake, wraps all-ones->0.
//  - Reset: s1_valid=0, out_valid=0, y=0, flag_z=0, flag_c=0, flag_v=0, op_count=0.
//    in_ready=1 on the first cycle after reset.
//  - Reset mid-operation: all in-flight results discarded, no handshake counted.
//  - Data regs need no reset except y/flags (defined above).
// CONFIGURATION
//  ALU_SAT_EN defined:
//  - 011 saturates unsigned: on carry, y=all-ones.
//  - 100 saturates unsigned: on borrow, y=0.
//  - flag_c/flag_v still report the unsaturated condition; flag_z reflects the saturated y.
//  ALU_SAT_EN undefined: modulo wrap as above; no saturation logic synthesised.
// TESTING
//  1. Reset: rst=1 for 2 cycles -> out_valid=0, y=0, flags=0, op_count=0, in_ready=1.
//  2. WIDTH=8, out_ready=1, issue a=8'hF0,b=8'h0F with sel 001,010,101 back-to-back
//     -> y=00,FF,FF on consecutive cycles, 2-edge latency.
//  3. Add a=8'h7F,b=8'h01 -> y=80,v=1,c=0. a=8'hFF,b=8'h01 -> y=00,z=1,c=1
//     (ALU_SAT_EN: y=FF,z=0,c=1).
//  4. Sub a=8'h00,b=8'h01 -> y=FF,c=1,v=0 (ALU_SAT_EN: y=00,z=1). a=8'h80,b=8'h01 -> y=7F,v=1.
//  5. Backpressure: out_ready=0 while streaming 4 ops -> in_ready low after 2 accepts,
//     y stable. Release -> remaining results in order, no loss, op_count=4.
//  6. Assert rst with 2 ops in flight -> next cycle out_valid=0, op_count=0. COUNT_W=2 wraps 3->0.

Source files
------------

// File: rtl/alu_pipe_if.sv
// ============================================================================
// Module      : alu_pipe_if
// Description : Operand/result handshake bundle for alu_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_pipe_if #(
    parameter int WIDTH   = 8,
    parameter int COUNT_W = 16
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [2:0]         sel;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   y;
    logic               flag_z;
    logic               flag_c;
    logic               flag_v;
    logic [COUNT_W-1:0] op_count;

    modport master (
        output in_valid, a, b, sel, out_ready,
        input  in_ready, out_valid, y, flag_z, flag_c, flag_v, op_count
    );

    modport slave (
        input  in_valid, a, b, sel, out_ready,
        output in_ready, out_valid, y, flag_z, flag_c, flag_v, op_count
    );
endinterface

`default_nettype wire

// File: rtl/alu_pipe.sv
// ============================================================================
// Module      : alu_pipe
// Description : Two-stage valid/ready ALU with status flags and a handoff
//               counter. Define ALU_SAT_EN for unsigned saturating add/sub.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_pipe #(
    parameter int WIDTH   = 8,
    parameter int COUNT_W = 16
) (
    input  wire logic clk,
    input  wire logic rst,
    alu_pipe_if.slave bus
);
    localparam int       c_MSB      = WIDTH - 1;
    localparam logic [2:0] c_OP_ZERO = 3'b000;
    localparam logic [2:0] c_OP_AND  = 3'b001;
    localparam logic [2:0] c_OP_OR   = 3'b010;
    localparam logic [2:0] c_OP_ADD  = 3'b011;
    localparam logic [2:0] c_OP_SUB  = 3'b100;
    localparam logic [2:0] c_OP_XOR  = 3'b101;
    localparam logic [2:0] c_OP_NOT  = 3'b110;
    localparam logic [2:0] c_OP_ONES = 3'b111;

    logic               s1_valid_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [2:0]         sel_q;

    logic               out_valid_q;
    logic [WIDTH-1:0]   y_q;
    logic               z_q;
    logic               c_q;
    logic               v_q;
    logic [COUNT_W-1:0] count_q;

    logic [WIDTH-1:0]   y_d;
    logic               c_d;
    logic               v_d;

    logic               w_adv2;
    logic               w_in_ready;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;

    assign w_adv2     = !out_valid_q || bus.out_ready;
    assign w_in_ready = !s1_valid_q || w_adv2;

    // Extra top bit of each result is the carry / borrow.
    assign w_sum  = {1'b0, a_q} + {1'b0, b_q};
    assign w_diff = {1'b0, a_q} - {1'b0, b_q};

    always_comb begin
        y_d = '0;
        c_d = 1'b0;
        v_d = 1'b0;
        case (sel_q)
            c_OP_ZERO: y_d = '0;
            c_OP_AND:  y_d = a_q & b_q;
            c_OP_OR:   y_d = a_q | b_q;
            c_OP_ADD: begin
                y_d = w_sum[c_MSB:0];
                c_d = w_sum[WIDTH];
                v_d = (a_q[c_MSB] == b_q[c_MSB]) && (w_sum[c_MSB] != a_q[c_MSB]);
`ifdef ALU_SAT_EN
                if (w_sum[WIDTH]) y_d = '1;
`endif
            end
            c_OP_SUB: begin
                y_d = w_diff[c_MSB:0];
                c_d = w_diff[WIDTH];
                v_d = (a_q[c_MSB] != b_q[c_MSB]) && (w_diff[c_MSB] != a_q[c_MSB]);
`ifdef ALU_SAT_EN
                if (w_diff[WIDTH]) y_d = '0;
`endif
            end
            c_OP_XOR:  y_d = a_q ^ b_q;
            c_OP_NOT:  y_d = ~a_q;
            c_OP_ONES: y_d = '1;
            default:   y_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
        end else if (w_in_ready) begin
            s1_valid_q <= bus.in_valid;
        end
    end

    // Operand registers carry no reset; s1_valid_q qualifies them.
    always_ff @(posedge clk) begin
        if (w_in_ready && bus.in_valid) begin
            a_q   <= bus.a;
            b_q   <= bus.b;
            sel_q <= bus.sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            y_q         <= '0;
            z_q         <= 1'b0;
            c_q         <= 1'b0;
            v_q         <= 1'b0;
        end else if (w_adv2) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                y_q <= y_d;
                z_q <= (y_d == '0);
                c_q <= c_d;
                v_q <= v_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (out_valid_q && bus.out_ready) begin
            count_q <= count_q + COUNT_W'(1);
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.y         = y_q;
    assign bus.flag_z    = z_q;
    assign bus.flag_c    = c_q;
    assign bus.flag_v    = v_q;
    assign bus.op_count  = count_q;

endmodule

`default_nettype wire
